// File: rtl/rr_port_if.sv
// rr_port_if: node-side capture ports and the shared outbound link of rr_port_arbiter.
interface rr_port_if #(
    parameter int NUM_IN = 4
);
    localparam int IW = NUM_IN > 1 ? $clog2(NUM_IN) : 1;
    logic [NUM_IN-1:0]      free_in;
    logic [NUM_IN-1:0]      put_in;
    logic [NUM_IN-1:0][7:0] payload_in;
    logic                   free_out;
    logic                   put_out;
    logic [7:0]             payload_out;
    logic [IW-1:0]          grant_id;
    logic                   proto_err;
    modport master (
        output free_in, put_out, payload_out, grant_id, proto_err,
        input  put_in, payload_in, free_out
    );
    modport slave (
        input  free_in, put_out, payload_out, grant_id, proto_err,
        output put_in, payload_in, free_out
    );
endinterface

// File: rtl/rr_port_arbiter.sv
// rr_port_arbiter: one-packet capture slot per input, drained round-robin onto one serial link.
module rr_port_arbiter #(
    parameter int NUM_IN    = 4,
    parameter int PKT_BYTES = 4
) (
    input logic       clock,
    input logic       reset_n,
    rr_port_if.master bus
);
    localparam int IW = NUM_IN > 1 ? $clog2(NUM_IN) : 1;
    localparam int BW = PKT_BYTES > 1 ? $clog2(PKT_BYTES) : 1;
    typedef enum logic {IDLE, SEND} state_t;
    state_t            state, state_d;
    logic [7:0]        slot [NUM_IN][PKT_BYTES];
    logic [BW-1:0]     cnt [NUM_IN];
    logic [NUM_IN-1:0] full, take, done, err, clear;
    logic [IW-1:0]     rr_ptr, pick, cand, grant;
    logic [BW-1:0]     idx;
    logic              last, put_d;
    logic [7:0]        data_d;
    always_comb begin
        take = '0;
        done = '0;
        err  = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            take[k] = bus.put_in[k] && !full[k];
            done[k] = take[k] && cnt[k] == BW'(PKT_BYTES - 1);
            err[k]  = (bus.put_in[k] && full[k]) || (!bus.put_in[k] && cnt[k] != '0);
        end
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            full          <= '0;
            bus.free_in   <= '1;
            bus.proto_err <= 1'b0;
            for (int k = 0; k < NUM_IN; k++) cnt[k] <= '0;
        end else begin
            bus.proto_err <= bus.proto_err | (|err);
            full          <= done | (full & ~clear);
            bus.free_in   <= ~(take | (full & ~clear));
            for (int k = 0; k < NUM_IN; k++) cnt[k] <= take[k] && !done[k] ? cnt[k] + 1'b1 : '0;
        end
    end
    always_ff @(posedge clock) begin
        for (int k = 0; k < NUM_IN; k++)
            if (take[k]) slot[k][cnt[k]] <= bus.payload_in[k];
    end
    // Scanning downward lets the nearest full slot after rr_ptr overwrite farther ones.
    always_comb begin
        pick = rr_ptr;
        cand = '0;
        for (int k = NUM_IN; k >= 1; k--) begin
            cand = IW'((int'(rr_ptr) + k) % NUM_IN);
            if (full[cand]) pick = cand;
        end
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end
    assign last = idx == BW'(PKT_BYTES - 1);
    always_comb begin
        state_d = state == IDLE ? ((|full) && bus.free_out ? SEND : IDLE) : (last ? IDLE : SEND);
    end
    always_comb begin
        clear = '0;
        for (int k = 0; k < NUM_IN; k++) clear[k] = state == SEND && last && grant == IW'(k);
        put_d  = state_d == SEND;
        data_d = !put_d ? 8'h00 : state == IDLE ? slot[pick][0] : slot[grant][idx + 1'b1];
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx             <= '0;
            grant           <= '0;
            rr_ptr          <= IW'(NUM_IN - 1);
            bus.put_out     <= 1'b0;
            bus.payload_out <= 8'h00;
        end else begin
            bus.put_out     <= put_d;
            bus.payload_out <= data_d;
            if (state == IDLE && state_d == SEND) begin
                grant  <= pick;
                rr_ptr <= pick;
                idx    <= '0;
            end else if (state == SEND) begin
                idx <= idx + 1'b1;
            end
        end
    end
    assign bus.grant_id = grant;
endmodule
